// File: rtl/hazard_fwd_unit_pkg.sv
// Shared constants for the hazard/forwarding unit: forward-select encoding and stage naming.
// The forward-select width derives from tracking depth so every consumer sizes it identically.
package hazard_fwd_unit_pkg;

   localparam int FWD_REGFILE = 0;
   localparam int STG_EX      = 1;
   localparam int STG_MEM     = 2;
   localparam int STG_WB      = 3;

   function automatic int fwd_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// ID-stage operand/destination info in, forwarding selects and pipeline control out.
// The master side drives decoded instruction info; the slave side is the hazard unit.
interface hazard_fwd_unit_if
   import hazard_fwd_unit_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int DEPTH  = 3,
   parameter int CNT_W  = 32
);
   logic                        id_valid;
   logic [REG_AW-1:0]           id_rs;
   logic [REG_AW-1:0]           id_rt;
   logic                        id_rs_used;
   logic                        id_rt_used;
   logic                        id_wreg;
   logic [REG_AW-1:0]           id_wdst;
   logic                        id_is_load;
   logic                        mem_freeze;
   logic                        id_flush;
   logic [fwd_width(DEPTH)-1:0] fwd_a;
   logic [fwd_width(DEPTH)-1:0] fwd_b;
   logic                        stall;
   logic                        bubble;
   logic [CNT_W-1:0]            stall_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wreg, id_wdst, id_is_load,
             mem_freeze, id_flush,
      input  fwd_a, fwd_b, stall, bubble, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wreg, id_wdst, id_is_load,
             mem_freeze, id_flush,
      output fwd_a, fwd_b, stall, bubble, stall_cnt
   );
endinterface

// File: rtl/hfu_src_match.sv
// Youngest-first search of the in-flight writer stages for one source operand.
// Purely combinational; reports whether the matching writer's result is forwardable yet.
module hfu_src_match
   import hazard_fwd_unit_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int DEPTH      = 3,
   parameter int ALU_AVAIL  = 1,
   parameter int LOAD_AVAIL = 2,
   parameter int ZERO_REG   = 1,
   parameter int FW         = fwd_width(DEPTH)
) (
   input  logic [REG_AW-1:0]            src,
   input  logic                         used,
   input  logic [DEPTH:1]               stg_v,
   input  logic [DEPTH:1][REG_AW-1:0]   stg_wdst,
   input  logic [DEPTH:1]               stg_ld,
   output logic                         hit,
   output logic [FW-1:0]                k,
   output logic                         ready
);

   // Walk oldest to youngest so the youngest match is the last one written.
   always_comb begin
      hit   = 1'b0;
      k     = '0;
      ready = 1'b0;
      if (used && !((ZERO_REG != 0) && (src == '0))) begin
         for (int s = DEPTH; s >= 1; s--) begin
            if (stg_v[s] && (stg_wdst[s] == src)) begin
               hit   = 1'b1;
               k     = FW'(s);
               ready = (s >= (stg_ld[s] ? LOAD_AVAIL : ALU_AVAIL));
            end
         end
      end
   end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Tracks DEPTH in-flight register writers and derives forwarding selects, stall and bubble.
// Selects/control are combinational from ID; tracking shifts each edge unless mem_freeze holds it.
module hazard_fwd_unit
   import hazard_fwd_unit_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int DEPTH      = 3,
   parameter int ALU_AVAIL  = 1,
   parameter int LOAD_AVAIL = 2,
   parameter int ZERO_REG   = 1,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   hazard_fwd_unit_if.slave bus
);

   localparam int FW = fwd_width(DEPTH);

   if (LOAD_AVAIL > DEPTH || ALU_AVAIL < 1) begin : g_param_chk
      $error("hazard_fwd_unit: LOAD_AVAIL must be <= DEPTH and ALU_AVAIL >= 1");
   end

   logic [DEPTH:1]             stg_v;
   logic [DEPTH:1][REG_AW-1:0] stg_wdst;
   logic [DEPTH:1]             stg_ld;

   logic          hit_a, hit_b, rdy_a, rdy_b;
   logic [FW-1:0] k_a, k_b;
   logic          hz, accept, wr_ok;
   logic [CNT_W-1:0] cnt_q;

   hfu_src_match #(
      .REG_AW(REG_AW), .DEPTH(DEPTH), .ALU_AVAIL(ALU_AVAIL),
      .LOAD_AVAIL(LOAD_AVAIL), .ZERO_REG(ZERO_REG), .FW(FW)
   ) u_match_a (
      .src(bus.id_rs), .used(bus.id_rs_used),
      .stg_v(stg_v), .stg_wdst(stg_wdst), .stg_ld(stg_ld),
      .hit(hit_a), .k(k_a), .ready(rdy_a)
   );

   hfu_src_match #(
      .REG_AW(REG_AW), .DEPTH(DEPTH), .ALU_AVAIL(ALU_AVAIL),
      .LOAD_AVAIL(LOAD_AVAIL), .ZERO_REG(ZERO_REG), .FW(FW)
   ) u_match_b (
      .src(bus.id_rt), .used(bus.id_rt_used),
      .stg_v(stg_v), .stg_wdst(stg_wdst), .stg_ld(stg_ld),
      .hit(hit_b), .k(k_b), .ready(rdy_b)
   );

   // A not-yet-ready youngest match blocks forwarding from any older writer.
   assign bus.fwd_a = (hit_a && rdy_a) ? k_a : FW'(FWD_REGFILE);
   assign bus.fwd_b = (hit_b && rdy_b) ? k_b : FW'(FWD_REGFILE);

   assign hz         = bus.id_valid & ~bus.id_flush & ((hit_a & ~rdy_a) | (hit_b & ~rdy_b));
   assign bus.stall  = hz | bus.mem_freeze;
   assign bus.bubble = (hz | bus.id_flush) & ~bus.mem_freeze;

   assign accept = bus.id_valid & ~hz & ~bus.id_flush;
   assign wr_ok  = bus.id_wreg & ((ZERO_REG == 0) || (bus.id_wdst != '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg_v    <= '0;
         stg_wdst <= '0;
         stg_ld   <= '0;
      end else if (!bus.mem_freeze) begin
         for (int s = DEPTH; s >= 2; s--) begin
            stg_v[s]    <= stg_v[s-1];
            stg_wdst[s] <= stg_wdst[s-1];
            stg_ld[s]   <= stg_ld[s-1];
         end
         stg_v[STG_EX]    <= accept & wr_ok;
         stg_wdst[STG_EX] <= bus.id_wdst;
         stg_ld[STG_EX]   <= bus.id_is_load;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (bus.stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Drives three configurations (default, DEPTH=4/LOAD_AVAIL=3, CNT_W=4) with shared ID stimulus
// and compares each against a queue-based model of the in-flight writer list.
module tb_hazard_fwd_unit;
   import hazard_fwd_unit_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       id_valid, id_rs_used, id_rt_used, id_wreg, id_is_load, mem_freeze, id_flush;
   logic [4:0] id_rs, id_rt, id_wdst;

   hazard_fwd_unit_if #(.DEPTH(3))              if0 ();
   hazard_fwd_unit_if #(.DEPTH(4))              if1 ();
   hazard_fwd_unit_if #(.DEPTH(3), .CNT_W(4))   if2 ();

   assign if0.id_valid = id_valid; assign if0.id_rs = id_rs; assign if0.id_rt = id_rt;
   assign if0.id_rs_used = id_rs_used; assign if0.id_rt_used = id_rt_used; assign if0.id_wreg = id_wreg;
   assign if0.id_wdst = id_wdst; assign if0.id_is_load = id_is_load;
   assign if0.mem_freeze = mem_freeze; assign if0.id_flush = id_flush;
   assign if1.id_valid = id_valid; assign if1.id_rs = id_rs; assign if1.id_rt = id_rt;
   assign if1.id_rs_used = id_rs_used; assign if1.id_rt_used = id_rt_used; assign if1.id_wreg = id_wreg;
   assign if1.id_wdst = id_wdst; assign if1.id_is_load = id_is_load;
   assign if1.mem_freeze = mem_freeze; assign if1.id_flush = id_flush;
   assign if2.id_valid = id_valid; assign if2.id_rs = id_rs; assign if2.id_rt = id_rt;
   assign if2.id_rs_used = id_rs_used; assign if2.id_rt_used = id_rt_used; assign if2.id_wreg = id_wreg;
   assign if2.id_wdst = id_wdst; assign if2.id_is_load = id_is_load;
   assign if2.mem_freeze = mem_freeze; assign if2.id_flush = id_flush;

   hazard_fwd_unit #(.DEPTH(3))                  u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   hazard_fwd_unit #(.DEPTH(4), .LOAD_AVAIL(3))  u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   hazard_fwd_unit #(.DEPTH(3), .CNT_W(4))       u_dut2 (.clk(clk), .rst(rst), .bus(if2));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: index 0 of each queue is the instruction that just left ID.
   typedef struct {bit v; int dst; bit ld;} ent_t;
   ent_t   pipe [3][$];
   int     cfg_depth [3] = '{3, 4, 3};
   int     cfg_la    [3] = '{2, 3, 2};
   longint cfg_max   [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};
   longint m_cnt [3];
   bit     m_hz [3], m_stall [3], m_bub [3];
   int     m_fa [3], m_fb [3];

   function automatic void m_reset();
      ent_t e;
      e = '{v: 1'b0, dst: 0, ld: 1'b0};
      for (int i = 0; i < 3; i++) begin
         pipe[i].delete();
         for (int j = 0; j < cfg_depth[i]; j++) pipe[i].push_back(e);
         m_cnt[i] = 0;
      end
   endfunction

   function automatic void m_lookup(input int i, input int src, input bit used,
                                    output bit hz, output int fwd);
      hz  = 1'b0;
      fwd = 0;
      if (!used || src == 0) return;
      for (int j = 0; j < pipe[i].size(); j++) begin
         if (pipe[i][j].v && pipe[i][j].dst == src) begin
            if (j + 1 >= (pipe[i][j].ld ? cfg_la[i] : 1)) fwd = j + 1;
            else hz = 1'b1;
            return;
         end
      end
   endfunction

   function automatic void m_eval(input int i);
      bit ha, hb;
      m_lookup(i, int'(id_rs), id_rs_used, ha, m_fa[i]);
      m_lookup(i, int'(id_rt), id_rt_used, hb, m_fb[i]);
      m_hz[i]    = id_valid && !id_flush && (ha || hb);
      m_stall[i] = m_hz[i] || mem_freeze;
      m_bub[i]   = (m_hz[i] || id_flush) && !mem_freeze;
   endfunction

   function automatic void m_edge(input int i);
      ent_t e;
      if (m_stall[i] && m_cnt[i] < cfg_max[i]) m_cnt[i]++;
      if (!mem_freeze) begin
         e.v   = id_valid && !m_hz[i] && !id_flush && id_wreg && (id_wdst != 0);
         e.dst = int'(id_wdst);
         e.ld  = id_is_load;
         void'(pipe[i].pop_back());
         pipe[i].push_front(e);
      end
   endfunction

   task automatic chk_inst(input int i, input logic [63:0] fa, input logic [63:0] fb,
                           input logic st, input logic bb, input logic [63:0] cnt);
      check($sformatf("fwd_a[%0d]", i), fa, m_fa[i]);
      check($sformatf("fwd_b[%0d]", i), fb, m_fb[i]);
      check($sformatf("stall[%0d]", i), st, m_stall[i]);
      check($sformatf("bubble[%0d]", i), bb, m_bub[i]);
      check($sformatf("stall_cnt[%0d]", i), cnt, m_cnt[i]);
   endtask

   task automatic settle();
      #1;
      for (int i = 0; i < 3; i++) m_eval(i);
      chk_inst(0, if0.fwd_a, if0.fwd_b, if0.stall, if0.bubble, if0.stall_cnt);
      chk_inst(1, if1.fwd_a, if1.fwd_b, if1.stall, if1.bubble, if1.stall_cnt);
      chk_inst(2, if2.fwd_a, if2.fwd_b, if2.stall, if2.bubble, if2.stall_cnt);
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) m_reset();
      else for (int i = 0; i < 3; i++) m_edge(i);
      @(negedge clk);
   endtask

   task automatic cycle();
      settle();
      advance();
   endtask

   task automatic set_in(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                         input bit wr, input int wd, input bit ld, input bit fz, input bit fl);
      id_valid = v;   id_rs = 5'(rs); id_rs_used = rsu; id_rt = 5'(rt); id_rt_used = rtu;
      id_wreg  = wr;  id_wdst = 5'(wd); id_is_load = ld; mem_freeze = fz; id_flush = fl;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      m_reset();
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      idle();
      m_reset();
      @(negedge clk);
      settle();
      check("rst_fwd_a", if0.fwd_a, 0);
      check("rst_stall", if0.stall, 0);
      check("rst_bubble", if0.bubble, 0);
      check("rst_cnt", if0.stall_cnt, 0);
      advance();
      rst = 1'b0;

      // lw $2 ; add $3,$2,$4
      set_in(1, 0, 0, 0, 0, 1, 2, 1, 0, 0); cycle();
      set_in(1, 2, 1, 4, 1, 1, 3, 0, 0, 0);
      settle();
      check("lu_stall", if0.stall, 1);
      check("lu_bubble", if0.bubble, 1);
      advance();
      settle();
      check("lu_stall_done", if0.stall, 0);
      check("lu_fwd_a", if0.fwd_a, 2);
      check("lu_cnt", if0.stall_cnt, 1);
      check("la3_still_stall", if1.stall, 1);
      advance();
      settle();
      check("la3_fwd_a", if1.fwd_a, 3);
      check("la3_stall_done", if1.stall, 0);
      check("la3_cnt", if1.stall_cnt, 2);
      advance();

      // add $5,$1,$1 ; sub $6,$5,$5
      do_reset();
      set_in(1, 1, 1, 1, 1, 1, 5, 0, 0, 0); cycle();
      set_in(1, 5, 1, 5, 1, 1, 6, 0, 0, 0);
      settle();
      check("alu_fwd_a", if0.fwd_a, 1);
      check("alu_fwd_b", if0.fwd_b, 1);
      check("alu_stall", if0.stall, 0);
      advance();

      // Youngest writer wins; $0 never forwards.
      do_reset();
      set_in(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); cycle();
      set_in(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); cycle();
      set_in(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      check("young_fwd_a", if0.fwd_a, 1);
      advance();
      set_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); cycle();
      set_in(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      settle();
      check("zero_fwd_a", if0.fwd_a, 0);
      check("zero_stall", if0.stall, 0);
      advance();

      // A not-yet-ready younger load shadows an older ready ALU write of the same register.
      do_reset();
      set_in(1, 0, 0, 0, 0, 1, 11, 0, 0, 0); cycle();
      set_in(1, 0, 0, 0, 0, 1, 11, 1, 0, 0); cycle();
      set_in(1, 11, 1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      check("shadow_stall", if0.stall, 1);
      check("shadow_fwd_a", if0.fwd_a, 0);
      advance();

      // lw $8 ; consumer with a 4-cycle memory freeze in the middle of its stall.
      do_reset();
      set_in(1, 0, 0, 0, 0, 1, 8, 1, 0, 0); cycle();
      set_in(1, 8, 1, 0, 0, 1, 12, 0, 0, 0); cycle();
      set_in(1, 8, 1, 0, 0, 1, 12, 0, 1, 0);
      for (int n = 0; n < 4; n++) begin
         settle();
         check("frz_stall", if1.stall, 1);
         check("frz_bubble", if1.bubble, 0);
         advance();
      end
      set_in(1, 8, 1, 0, 0, 1, 12, 0, 0, 0); cycle();
      settle();
      check("frz_fwd_a", if1.fwd_a, 3);
      check("frz_stall_done", if1.stall, 0);
      check("frz_cnt", if1.stall_cnt, 6);
      advance();

      // Flush beats a hazard; the squashed writer never enters tracking.
      do_reset();
      set_in(1, 0, 0, 0, 0, 1, 9, 1, 0, 0); cycle();
      set_in(1, 9, 1, 0, 0, 1, 10, 0, 0, 1);
      settle();
      check("flush_stall", if0.stall, 0);
      check("flush_bubble", if0.bubble, 1);
      advance();
      set_in(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      check("flush_no_fwd", if0.fwd_a, 0);
      advance();

      // Reset asserted in the middle of a stall.
      do_reset();
      set_in(1, 0, 0, 0, 0, 1, 2, 1, 0, 0); cycle();
      set_in(1, 2, 1, 0, 0, 1, 3, 0, 0, 0); cycle();
      settle();
      check("mid_stall", if1.stall, 1);
      check("mid_cnt", if1.stall_cnt, 1);
      rst = 1'b1;
      m_reset();
      #1;
      check("rst_mid_stall", if1.stall, 0);
      check("rst_mid_cnt", if1.stall_cnt, 0);
      advance();
      rst = 1'b0;
      settle();
      check("post_rst_stall", if1.stall, 0);
      advance();

      // Counter saturation on the narrow instance.
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int n = 0; n < 20; n++) cycle();
      settle();
      check("sat_cnt4", if2.stall_cnt, 15);
      check("sat_cnt32", if0.stall_cnt, 20);
      advance();

      // Randomized traffic on a small register window to provoke frequent matches.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         set_in($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 9) < 7,
                $urandom_range(0, 7), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                $urandom_range(0, 7), $urandom_range(0, 9) < 3,
                $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8);
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1;
            m_reset();
            cycle();
            rst = 1'b0;
         end else begin
            cycle();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
